// File: rtl/bcd_display_mux_if.sv
// Display-side bus of bcd_display_mux: digit capture inputs and multiplexed segment outputs.
// The master drives digits and load; the slave (the display mux) drives seg/an/err.
interface bcd_display_mux_if;
  logic       load;
  logic [3:0] ms_digit;
  logic [3:0] ls_digit;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (
    output load, ms_digit, ls_digit, blank_lz,
    input  seg, an, err
  );

  modport slave (
    input  load, ms_digit, ls_digit, blank_lz,
    output seg, an, err
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver for a BCD sum: captures digits on load, alternates
// units/tens every REFRESH_DIV cycles with one dead cycle per switch, registered outputs.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  bcd_display_mux_if.slave  bus
);

  localparam int unsigned CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SegOff    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AnOff     = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [3:0]    ms_q, ls_q;
  logic          err_q;
  logic [CW-1:0] count_q, count_d;
  logic          sel_q, sel_d;
  logic [6:0]    seg_q, seg_d, seg_raw;
  logic [1:0]    an_q, an_d, an_raw;

  // Active-high segment code {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    count_d = count_q + CW'(1);
    sel_d   = sel_q;
    if (count_q == CntMax) begin
      count_d = '0;
      sel_d   = ~sel_q;
    end
  end

  // count_q == 0 is the dead slot: everything dark so the previous digit cannot ghost.
  always_comb begin
    seg_raw = 7'h00;
    an_raw  = 2'b00;
    if (count_q != '0) begin
      if (sel_q) begin
        an_raw  = 2'b10;
        seg_raw = (bus.blank_lz && (ms_q == 4'd0)) ? 7'h00 : decode(ms_q);
      end else begin
        an_raw  = 2'b01;
        seg_raw = decode(ls_q);
      end
    end
    seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    an_d  = an_raw ^ {2{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      sel_q   <= 1'b0;
      seg_q   <= SegOff;
      an_q    <= AnOff;
    end else begin
      count_q <= count_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_q  <= 4'd0;
      ls_q  <= 4'd0;
      err_q <= 1'b0;
    end else if (bus.load) begin
      ms_q  <= bus.ms_digit;
      ls_q  <= bus.ls_digit;
      err_q <= (bus.ms_digit > 4'd9) || (bus.ls_digit > 4'd9);
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux at REFRESH_DIV=4: one active-high and one active-low
// instance share stimulus; every output edge is checked against the slot it should show.
module tb_bcd_display_mux;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   k;  // rising edges since reset release

  bcd_display_mux_if bus0 ();
  bcd_display_mux_if bus1 ();

  bcd_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  bcd_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] ms;
    logic [3:0] ls;
    logic       blz;
    logic [6:0] units;
    logic [6:0] tens;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] ms, input logic [3:0] ls,
                       input logic blz);
    bus0.load = ld; bus0.ms_digit = ms; bus0.ls_digit = ls; bus0.blank_lz = blz;
    bus1.load = ld; bus1.ms_digit = ms; bus1.ls_digit = ls; bus1.blank_lz = blz;
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  // n edges, each checked against the slot implied by the edge index since reset release.
  task automatic run_slots(input logic [6:0] u, input logic [6:0] t, input logic e,
                           input int n);
    int p;
    logic [1:0] ea;
    logic [6:0] es;
    for (int i = 0; i < n; i++) begin
      tick();
      p = (k - 1) % 8;
      if (p == 0 || p == 4) begin
        ea = 2'b00; es = 7'h00;
      end else if (p < 4) begin
        ea = 2'b01; es = u;
      end else begin
        ea = 2'b10; es = t;
      end
      chk("an_hi", {6'd0, bus0.an}, {6'd0, ea});
      chk("seg_hi", {1'b0, bus0.seg}, {1'b0, es});
      chk("an_lo", {6'd0, bus1.an}, {6'd0, ~ea});
      chk("seg_lo", {1'b0, bus1.seg}, {1'b0, ~es});
      chk("err", {7'd0, bus0.err}, {7'd0, e});
      chk("never_both_an", {7'd0, bus0.an == 2'b11}, 8'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg_hi"}, {1'b0, bus0.seg}, 8'h00);
    chk({tag, "_an_hi"}, {6'd0, bus0.an}, 8'h00);
    chk({tag, "_seg_lo"}, {1'b0, bus1.seg}, 8'h7F);
    chk({tag, "_an_lo"}, {6'd0, bus1.an}, 8'h03);
    chk({tag, "_err"}, {7'd0, bus0.err}, 8'h00);
  endtask

  vec_t vecs [11];

  initial begin
    checks = 0;
    errors = 0;
    k      = 0;
    vecs[0]  = '{1'b1, 4'd1, 4'd4, 1'b0, 7'h66, 7'h06, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 4'd7, 1'b1, 7'h07, 7'h00, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 4'd7, 1'b0, 7'h07, 7'h3F, 1'b0};  // blank_lz dropped, no load
    vecs[3]  = '{1'b1, 4'd0, 4'hC, 1'b0, 7'h40, 7'h3F, 1'b1};
    vecs[4]  = '{1'b1, 4'd1, 4'd0, 1'b0, 7'h3F, 7'h06, 1'b0};
    vecs[5]  = '{1'b1, 4'd9, 4'd8, 1'b1, 7'h7F, 7'h6F, 1'b0};
    vecs[6]  = '{1'b1, 4'd2, 4'd3, 1'b0, 7'h4F, 7'h5B, 1'b0};
    vecs[7]  = '{1'b1, 4'd5, 4'd6, 1'b0, 7'h7D, 7'h6D, 1'b0};
    vecs[8]  = '{1'b1, 4'd0, 4'd0, 1'b1, 7'h3F, 7'h00, 1'b0};
    vecs[9]  = '{1'b1, 4'hF, 4'd9, 1'b0, 7'h6F, 7'h40, 1'b1};
    vecs[10] = '{1'b1, 4'd0, 4'hA, 1'b1, 7'h40, 7'h00, 1'b1};

    drive(1'b0, 4'd0, 4'd0, 1'b0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    tick();
    tick();
    chk_reset_outputs("reset_held");
    reset_n = 1'b1;
    k = 0;

    // No load yet: held digits 0 shown in both slots.
    run_slots(7'h3F, 7'h3F, 1'b0, 16);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].ms, vecs[i].ls, vecs[i].blz);
      if (vecs[i].ld) begin
        tick();
        drive(1'b0, vecs[i].ms, vecs[i].ls, vecs[i].blz);
        chk("err_at_load", {7'd0, bus0.err}, {7'd0, vecs[i].err});
      end
      run_slots(vecs[i].units, vecs[i].tens, vecs[i].err, 8);
    end

    // Load coincident with the wrap: next edge (k%4==0) has count 3 -> 0.
    drive(1'b0, 4'd3, 4'd8, 1'b0);
    while (k % 4 != 3) tick();
    drive(1'b1, 4'd3, 4'd8, 1'b0);
    tick();
    drive(1'b0, 4'd3, 4'd8, 1'b0);
    run_slots(7'h7F, 7'h4F, 1'b0, 10);

    // Load mid-slot right after the dead cycle.
    while (k % 4 != 1) tick();
    drive(1'b1, 4'd7, 4'd2, 1'b0);
    tick();
    drive(1'b0, 4'd7, 4'd2, 1'b0);
    run_slots(7'h5B, 7'h07, 1'b0, 8);

    // Reset pulsed mid-slot with err set: outputs go dark without a clock edge.
    drive(1'b1, 4'd1, 4'hB, 1'b0);
    tick();
    drive(1'b0, 4'd1, 4'hB, 1'b0);
    run_slots(7'h40, 7'h06, 1'b1, 2);
    while (((k - 1) % 8) != 2) tick();
    chk("pre_reset_seg_lo", {1'b0, bus1.seg}, {1'b0, ~7'h40});
    chk("pre_reset_an_lo", {6'd0, bus1.an}, 8'h02);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    tick();
    chk_reset_outputs("mid_reset_held");
    reset_n = 1'b1;
    k = 0;
    run_slots(7'h3F, 7'h3F, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
